// File: rtl/cx_dma_burst_splitter.sv
// Splits one linear DMA descriptor into AXI-legal INCR bursts. Each burst
// obtains a tracker ID before it is issued on the read or write request port.
module cx_dma_burst_splitter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 24,
  parameter int MEM_DATA_WIDTH  = 64,
  parameter int MAX_BURST_BEATS = 256,
  parameter int BOUNDARY_BYTES  = 4096,
  parameter int TRACK_ID_WIDTH  = 4,
  parameter int MEM_ID_WIDTH    = 6,
  parameter int SIZE_WIDTH      = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              s_desc_valid,
  output logic                              s_desc_ready,
  input  logic [ADDR_WIDTH+LEN_WIDTH:0]     s_desc_data,
  output logic                              m_alloc_req_valid,
  input  logic                              m_alloc_req_ready,
  output logic [2*ADDR_WIDTH-1:0]           m_alloc_req_data,
  output logic [MEM_ID_WIDTH-1:0]           m_alloc_req_id,
  input  logic                              s_alloc_resp_valid,
  output logic                              s_alloc_resp_ready,
  input  logic [TRACK_ID_WIDTH-1:0]         s_alloc_resp_data,
  input  logic [MEM_ID_WIDTH-1:0]           s_alloc_resp_id,
  output logic                              m_rd_req_valid,
  input  logic                              m_rd_req_ready,
  output logic [2*ADDR_WIDTH+SIZE_WIDTH-1:0] m_rd_req_data,
  output logic [MEM_ID_WIDTH-1:0]           m_rd_req_id,
  output logic                              m_wr_req_valid,
  input  logic                              m_wr_req_ready,
  output logic [2*ADDR_WIDTH+SIZE_WIDTH-1:0] m_wr_req_data,
  output logic [MEM_ID_WIDTH-1:0]           m_wr_req_id,
  output logic                              o_busy,
  output logic                              o_err
);
  localparam int BEAT_BYTES = MEM_DATA_WIDTH / 8;
  localparam int SIZE       = $clog2(BEAT_BYTES);
  localparam int BND_LOG    = $clog2(BOUNDARY_BYTES);
  localparam int AW1        = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, CALC, ALLOC, WAIT_ID, ISSUE} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]     burst_base_q, burst_base_d;
  logic [ADDR_WIDTH-1:0]     burst_end_q, burst_end_d;
  logic [LEN_WIDTH-1:0]      rem_bytes_q, rem_bytes_d;
  logic [AW1-1:0]            burst_bytes_q, burst_bytes_d;
  logic [TRACK_ID_WIDTH-1:0] tid_q, tid_d;
  logic                      dir_q, dir_d;
  logic                      err_q, err_d;

  logic                      desc_wr, desc_bad;
  logic [ADDR_WIDTH-1:0]     desc_base;
  logic [LEN_WIDTH-1:0]      desc_len;
  logic [AW1-1:0]            desc_sum;
  logic [AW1-1:0]            rem_beats, to_bound, beats, calc_bytes, calc_end;
  logic                      req_ready, issue;
  logic [2*ADDR_WIDTH+SIZE_WIDTH-1:0] req_data;
  logic                      unused_bits;

  assign desc_wr   = s_desc_data[ADDR_WIDTH+LEN_WIDTH];
  assign desc_base = s_desc_data[ADDR_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
  assign desc_len  = s_desc_data[LEN_WIDTH-1:0];
  assign desc_sum  = AW1'(desc_base) + AW1'(desc_len);
  assign desc_bad  = (desc_len == '0) || (|desc_base[SIZE-1:0]) ||
                     (|desc_len[SIZE-1:0]) || desc_sum[ADDR_WIDTH];

  // Burst sizing is done one bit wider than the address so the distance to
  // the boundary (up to BOUNDARY_BYTES itself) never wraps before the min.
  always_comb begin
    rem_beats = AW1'(rem_bytes_q >> SIZE);
    to_bound  = (AW1'(BOUNDARY_BYTES) - AW1'(cur_addr_q[BND_LOG-1:0])) >> SIZE;
    beats     = rem_beats;
    if (beats > AW1'(MAX_BURST_BEATS)) beats = AW1'(MAX_BURST_BEATS);
    if (beats > to_bound)              beats = to_bound;
    calc_bytes = beats << SIZE;
    calc_end   = AW1'(cur_addr_q) + calc_bytes - AW1'(1);
  end

  assign req_ready = dir_q ? m_wr_req_ready : m_rd_req_ready;

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    rem_bytes_d   = rem_bytes_q;
    dir_d         = dir_q;
    burst_base_d  = burst_base_q;
    burst_end_d   = burst_end_q;
    burst_bytes_d = burst_bytes_q;
    tid_d         = tid_q;
    err_d         = 1'b0;
    case (state_q)
      IDLE: if (s_desc_valid) begin
        if (desc_bad) begin
          err_d = 1'b1;
        end else begin
          cur_addr_d  = desc_base;
          rem_bytes_d = desc_len;
          dir_d       = desc_wr;
          state_d     = CALC;
        end
      end
      CALC: begin
        burst_base_d  = cur_addr_q;
        burst_end_d   = calc_end[ADDR_WIDTH-1:0];
        burst_bytes_d = calc_bytes;
        state_d       = ALLOC;
      end
      ALLOC: if (m_alloc_req_ready) state_d = WAIT_ID;
      WAIT_ID: if (s_alloc_resp_valid) begin
        tid_d   = s_alloc_resp_data;
        state_d = ISSUE;
      end
      ISSUE: if (req_ready) begin
        cur_addr_d  = cur_addr_q + burst_bytes_q[ADDR_WIDTH-1:0];
        rem_bytes_d = rem_bytes_q - LEN_WIDTH'(burst_bytes_q);
        state_d     = (rem_bytes_d == '0) ? IDLE : CALC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      rem_bytes_q   <= '0;
      dir_q         <= 1'b0;
      burst_base_q  <= '0;
      burst_end_q   <= '0;
      burst_bytes_q <= '0;
      tid_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      rem_bytes_q   <= rem_bytes_d;
      dir_q         <= dir_d;
      burst_base_q  <= burst_base_d;
      burst_end_q   <= burst_end_d;
      burst_bytes_q <= burst_bytes_d;
      tid_q         <= tid_d;
      err_q         <= err_d;
    end
  end

  // Outputs decode the registered state; data is zeroed whenever not valid.
  assign issue              = (state_q == ISSUE);
  assign s_desc_ready       = (state_q == IDLE);
  assign s_alloc_resp_ready = (state_q == WAIT_ID);
  assign m_alloc_req_valid  = (state_q == ALLOC);
  assign m_alloc_req_data   = m_alloc_req_valid ? {burst_base_q, burst_end_q} : '0;
  assign m_alloc_req_id     = '0;
  assign req_data           = {burst_base_q, burst_end_q, SIZE_WIDTH'(SIZE)};
  assign m_rd_req_valid     = issue & ~dir_q;
  assign m_wr_req_valid     = issue & dir_q;
  assign m_rd_req_data      = m_rd_req_valid ? req_data : '0;
  assign m_wr_req_data      = m_wr_req_valid ? req_data : '0;
  assign m_rd_req_id        = m_rd_req_valid ? MEM_ID_WIDTH'(tid_q) : '0;
  assign m_wr_req_id        = m_wr_req_valid ? MEM_ID_WIDTH'(tid_q) : '0;
  assign o_busy             = (state_q != IDLE);
  assign o_err              = err_q;

  assign unused_bits = ^{desc_sum[ADDR_WIDTH-1:0], calc_end[ADDR_WIDTH],
                         burst_bytes_q[ADDR_WIDTH], s_alloc_resp_id};
endmodule

// File: tb/tb_cx_dma_burst_splitter.sv
// Directed and randomized descriptors against a queue-based burst model.
module tb_cx_dma_burst_splitter;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        s_desc_valid, s_desc_ready;
  logic [56:0] s_desc_data;
  logic        m_alloc_req_valid, m_alloc_req_ready;
  logic [63:0] m_alloc_req_data;
  logic [5:0]  m_alloc_req_id;
  logic        s_alloc_resp_valid, s_alloc_resp_ready;
  logic [3:0]  s_alloc_resp_data;
  logic [5:0]  s_alloc_resp_id;
  logic        m_rd_req_valid, m_rd_req_ready;
  logic [66:0] m_rd_req_data;
  logic [5:0]  m_rd_req_id;
  logic        m_wr_req_valid, m_wr_req_ready;
  logic [66:0] m_wr_req_data;
  logic [5:0]  m_wr_req_id;
  logic        o_busy, o_err;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int al_hs, rd_hs, wr_hs;

  always #5 i_clk = ~i_clk;

  cx_dma_burst_splitter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready), .s_desc_data(s_desc_data),
    .m_alloc_req_valid(m_alloc_req_valid), .m_alloc_req_ready(m_alloc_req_ready),
    .m_alloc_req_data(m_alloc_req_data), .m_alloc_req_id(m_alloc_req_id),
    .s_alloc_resp_valid(s_alloc_resp_valid), .s_alloc_resp_ready(s_alloc_resp_ready),
    .s_alloc_resp_data(s_alloc_resp_data), .s_alloc_resp_id(s_alloc_resp_id),
    .m_rd_req_valid(m_rd_req_valid), .m_rd_req_ready(m_rd_req_ready),
    .m_rd_req_data(m_rd_req_data), .m_rd_req_id(m_rd_req_id),
    .m_wr_req_valid(m_wr_req_valid), .m_wr_req_ready(m_wr_req_ready),
    .m_wr_req_data(m_wr_req_data), .m_wr_req_id(m_wr_req_id),
    .o_busy(o_busy), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tally handshakes present in the cycle about to close, then advance.
  task automatic step();
    if (m_alloc_req_valid && m_alloc_req_ready) al_hs++;
    if (m_rd_req_valid && m_rd_req_ready) rd_hs++;
    if (m_wr_req_valid && m_wr_req_ready) wr_hs++;
    @(posedge i_clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_desc_ready"}, s_desc_ready, 1);
    chk({tag, "_alloc_valid"}, m_alloc_req_valid, 0);
    chk({tag, "_alloc_data"}, m_alloc_req_data, 0);
    chk({tag, "_resp_ready"}, s_alloc_resp_ready, 0);
    chk({tag, "_rd_valid"}, m_rd_req_valid, 0);
    chk({tag, "_wr_valid"}, m_wr_req_valid, 0);
    chk({tag, "_rd_data"}, m_rd_req_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  // Reference: greedy split by remaining beats, max burst, and 4 KB boundary.
  task automatic run_desc(input bit wr, input logic [31:0] base, input int len,
                          input int bpa, input int bpr, input int bpq, input int fid);
    logic [31:0] eb[$];
    logic [31:0] ee[$];
    longint a, r, lim, tob;
    logic [3:0]  id;
    logic [66:0] rq;
    a = base; r = len;
    while (r > 0) begin
      lim = r / 8;
      if (lim > 256) lim = 256;
      tob = (4096 - (a % 4096)) / 8;
      if (tob < lim) lim = tob;
      eb.push_back(32'(a));
      ee.push_back(32'(a + lim * 8 - 1));
      a += lim * 8;
      r -= lim * 8;
    end
    al_hs = 0; rd_hs = 0; wr_hs = 0;
    s_desc_valid = 1'b1;
    s_desc_data  = {wr, base, 24'(len)};
    chk("desc_ready_idle", s_desc_ready, 1);
    step();
    s_desc_valid = 1'b0; s_desc_data = '0;
    chk("busy_rise", o_busy, 1);
    chk("desc_ready_busy", s_desc_ready, 0);
    chk("no_err", o_err, 0);
    foreach (eb[i]) begin
      step();
      chk("alloc_valid", m_alloc_req_valid, 1);
      chk("alloc_data", m_alloc_req_data, {eb[i], ee[i]});
      chk("alloc_id", m_alloc_req_id, 0);
      repeat (bpa) begin
        step();
        chk("alloc_hold_valid", m_alloc_req_valid, 1);
        chk("alloc_hold_data", m_alloc_req_data, {eb[i], ee[i]});
        chk("desc_ready_hold", s_desc_ready, 0);
      end
      m_alloc_req_ready = 1'b1;
      step();
      m_alloc_req_ready = 1'b0;
      chk("alloc_drop", m_alloc_req_valid, 0);
      chk("resp_ready", s_alloc_resp_ready, 1);
      repeat (bpr) begin
        step();
        chk("resp_ready_hold", s_alloc_resp_ready, 1);
        chk("no_early_req", m_rd_req_valid | m_wr_req_valid, 0);
        chk("desc_ready_wait", s_desc_ready, 0);
      end
      id = (fid >= 0) ? 4'(fid) : 4'($urandom_range(0, 15));
      s_alloc_resp_valid = 1'b1;
      s_alloc_resp_data  = id;
      s_alloc_resp_id    = 6'($urandom);
      step();
      s_alloc_resp_valid = 1'b0;
      rq = {eb[i], ee[i], 3'd3};
      chk("req_valid", wr ? m_wr_req_valid : m_rd_req_valid, 1);
      chk("other_valid", wr ? m_rd_req_valid : m_wr_req_valid, 0);
      chk("req_data", wr ? m_wr_req_data : m_rd_req_data, rq);
      chk("req_id", wr ? m_wr_req_id : m_rd_req_id, {2'b00, id});
      repeat (bpq) begin
        step();
        chk("req_hold_valid", wr ? m_wr_req_valid : m_rd_req_valid, 1);
        chk("req_hold_data", wr ? m_wr_req_data : m_rd_req_data, rq);
        chk("desc_ready_req", s_desc_ready, 0);
      end
      if (wr) m_wr_req_ready = 1'b1; else m_rd_req_ready = 1'b1;
      step();
      m_rd_req_ready = 1'b0; m_wr_req_ready = 1'b0;
      chk("req_drop", m_rd_req_valid | m_wr_req_valid, 0);
      chk("busy_after_issue", o_busy, (i != eb.size() - 1));
    end
    chk("desc_ready_done", s_desc_ready, 1);
    chk("alloc_hs_count", al_hs, eb.size());
    chk("rd_hs_count", rd_hs, wr ? 0 : eb.size());
    chk("wr_hs_count", wr_hs, wr ? eb.size() : 0);
  endtask

  task automatic bad_desc(input logic [31:0] base, input int len);
    al_hs = 0;
    s_desc_valid = 1'b1;
    s_desc_data  = {1'b0, base, 24'(len)};
    chk("bad_ready", s_desc_ready, 1);
    step();
    s_desc_valid = 1'b0; s_desc_data = '0;
    chk("bad_err_pulse", o_err, 1);
    chk("bad_ready_after", s_desc_ready, 1);
    chk("bad_busy", o_busy, 0);
    step();
    chk("bad_err_clear", o_err, 0);
    chk("bad_no_alloc", m_alloc_req_valid, 0);
    chk("bad_alloc_hs", al_hs, 0);
  endtask

  initial begin
    i_rst = 1'b1;
    s_desc_valid = 1'b0; s_desc_data = '0;
    m_alloc_req_ready = 1'b0;
    s_alloc_resp_valid = 1'b0; s_alloc_resp_data = '0; s_alloc_resp_id = '0;
    m_rd_req_ready = 1'b0; m_wr_req_ready = 1'b0;
    step(); step();
    chk_idle_outputs("reset");
    i_rst = 1'b0;
    step();

    run_desc(1'b0, 32'h0000_1000, 64, 0, 0, 0, 5);
    run_desc(1'b1, 32'h0000_0FF0, 32, 0, 0, 0, -1);
    run_desc(1'b0, 32'h0000_0000, 4096, 0, 0, 0, -1);
    run_desc(1'b0, 32'h0000_0F00, 512, 10, 7, 10, -1);

    bad_desc(32'h0000_1004, 64);
    bad_desc(32'h0000_1000, 0);
    bad_desc(32'h0000_1000, 12);
    bad_desc(32'hFFFF_FFF8, 16);

    // Abort while waiting for the tracker ID.
    s_desc_valid = 1'b1; s_desc_data = {1'b0, 32'h0000_2000, 24'd128};
    step();
    s_desc_valid = 1'b0; s_desc_data = '0;
    step();
    m_alloc_req_ready = 1'b1;
    step();
    m_alloc_req_ready = 1'b0;
    chk("pre_rst_resp_ready", s_alloc_resp_ready, 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk_idle_outputs("mid_rst");
    step();
    chk("post_rst_no_req", m_rd_req_valid | m_wr_req_valid | m_alloc_req_valid, 0);
    run_desc(1'b1, 32'h0000_3000, 64, 0, 0, 0, -1);

    for (int k = 0; k < 8; k++) begin
      run_desc(1'($urandom), 32'($urandom_range(0, 32'h3FFF)) & 32'hFFFF_FFF8,
               8 * $urandom_range(1, 600), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
